// File: rtl/serial_demux_1_8_pkg.sv
// Shared constants and types for the 8:1 serial link receiver (serial_demux_1_8).
// FRAME_BITS / SLOT_W are shared with the transmitter-side mux select counter.
package serial_demux_1_8_pkg;

  localparam int FRAME_BITS = 8;
  localparam int SLOT_W     = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_BITS - 1);

  // ST_PAR is only reachable when SERIAL_DEMUX_PARITY_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PAR  = 2'd2
  } state_e;

  // Map the slot-ordered buffer onto q: slot k -> q[k] (lsb_first) or q[7-k].
  function automatic logic [FRAME_BITS-1:0] slot_to_q(input logic [FRAME_BITS-1:0] frame,
                                                      input bit lsb_first);
    logic [FRAME_BITS-1:0] r;
    for (int i = 0; i < FRAME_BITS; i++) begin
      r[i] = lsb_first ? frame[i] : frame[FRAME_BITS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_demux_1_8_if.sv
// Bus bundle between the serial link front end and serial_demux_1_8.
// Handshake: there is no ready; din/start are sampled on every rising clk
// edge where din_valid is high and ignored otherwise. q_valid is a one-cycle
// strobe marking the cycle in which q (and parity_err) carry a new frame.
interface serial_demux_1_8_if;
  import serial_demux_1_8_pkg::*;

  logic                  din;
  logic                  din_valid;
  logic                  start;
  logic [FRAME_BITS-1:0] q;
  logic                  q_valid;
  logic                  busy;
  logic [SLOT_W-1:0]     slot;
  logic                  parity_err;
  state_e                state_dbg;

  modport master (
    output din, din_valid, start,
    input  q, q_valid, busy, slot, parity_err, state_dbg
  );

  modport slave (
    input  din, din_valid, start,
    output q, q_valid, busy, slot, parity_err, state_dbg
  );

endinterface

// File: rtl/serial_demux_1_8_demux_1_8.sv
// demux_1_8: combinational 1:8 decoder turning a slot index plus a write
// strobe into one-hot per-slot write enables for the receive buffer.
module demux_1_8
  import serial_demux_1_8_pkg::*;
(
  input  logic [SLOT_W-1:0]     slot,
  input  logic                  we,
  output logic [FRAME_BITS-1:0] wen
);

  // One-hot enable for the addressed slot, all-zero when not writing.
  always_comb begin
    wen = '0;
    if (we) wen[slot] = 1'b1;
  end

endmodule

// File: rtl/serial_demux_1_8.sv
// serial_demux_1_8: serial-to-parallel receiver for the 8:1 mux serial link.
// Optional feature macro: SERIAL_DEMUX_PARITY_EN (adds an even-parity bit
// after slot 7 and the PAR state; otherwise parity_err is tied low).
module serial_demux_1_8
  import serial_demux_1_8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  serial_demux_1_8_if.slave  bus
);

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d, wr_slot;
  logic [FRAME_BITS-1:0] buf_q, buf_d, wen, q_q, q_d;
  logic                  q_valid_q, q_valid_d;
  logic                  wr_en, done, busy;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a qualified start always (re)opens a frame in RECV.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.din_valid && bus.start) state_d = ST_RECV;
      ST_RECV: if (bus.din_valid && !bus.start && slot_q == LAST_SLOT) begin
`ifdef SERIAL_DEMUX_PARITY_EN
        state_d = ST_PAR;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_PAR:  if (bus.din_valid) state_d = bus.start ? ST_RECV : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // A data write happens on any qualified start, or any valid bit in RECV.
  // The parity bit in PAR is not a data write.
  assign wr_en   = bus.din_valid && (bus.start || state_q == ST_RECV);
  assign wr_slot = bus.start ? '0 : slot_q;

  demux_1_8 u_demux (
    .slot (wr_slot),
    .we   (wr_en),
    .wen  (wen)
  );

  // Buffer update, slot advance and frame completion.
  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (wen[k]) buf_d[k] = bus.din;
    end
    // Slot 7 + 1 wraps to 0, which only happens as a frame fills up.
    slot_d = wr_en ? wr_slot + SLOT_W'(1) : slot_q;
`ifdef SERIAL_DEMUX_PARITY_EN
    done = (state_q == ST_PAR) && bus.din_valid && !bus.start;
`else
    done = (state_q == ST_RECV) && bus.din_valid && !bus.start && (slot_q == LAST_SLOT);
`endif
    q_valid_d = done;
    q_d       = done ? slot_to_q(buf_d, LSB_FIRST) : q_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= '0;
      slot_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      slot_q    <= slot_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

`ifdef SERIAL_DEMUX_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Even parity over data plus parity bit; flagged only with q_valid.
  always_comb begin
    parity_err_d = done && (^{buf_q, bus.din});
  end

  // Parity error strobe register.
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.q         = q_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.busy      = busy;
  assign bus.slot      = slot_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_serial_demux_1_8.sv
// Testbench for serial_demux_1_8: one LSB-first and one MSB-first instance
// share the same serial stimulus; a scoreboard pairs each frame with q_valid.
module tb_serial_demux_1_8;
  import serial_demux_1_8_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic start = 1'b0;

  serial_demux_1_8_if if_a ();
  serial_demux_1_8_if if_b ();

  assign if_a.din = din;
  assign if_a.din_valid = din_valid;
  assign if_a.start = start;
  assign if_b.din = din;
  assign if_b.din_valid = din_valid;
  assign if_b.start = start;

  serial_demux_1_8 #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  serial_demux_1_8 #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int checks = 0;
  int failures = 0;

  // Expected {parity_err, q} per completed frame, one queue per instance.
  logic [8:0] exp_a_q[$];
  logic [8:0] exp_b_q[$];

`ifdef SERIAL_DEMUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (if_a.q_valid === 1'b1) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        failures++;
        $display("FAIL sb_a_unexpected_q_valid got q=%h perr=%b", if_a.q, if_a.parity_err);
      end else begin
        e = exp_a_q.pop_front();
        if ({if_a.parity_err, if_a.q} !== e) begin
          failures++;
          $display("FAIL sb_a_frame got=%h exp=%h", {if_a.parity_err, if_a.q}, e);
        end
      end
    end
    if (if_b.q_valid === 1'b1) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        failures++;
        $display("FAIL sb_b_unexpected_q_valid got q=%h perr=%b", if_b.q, if_b.parity_err);
      end else begin
        e = exp_b_q.pop_front();
        if ({if_b.parity_err, if_b.q} !== e) begin
          failures++;
          $display("FAIL sb_b_frame got=%h exp=%h", {if_b.parity_err, if_b.q}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic send_bit(input logic b, input logic st);
    din = b;
    din_valid = 1'b1;
    start = st;
    tick();
    din_valid = 1'b0;
    start = 1'b0;
  endtask

  // Checks slot/busy/q_valid after each accepted bit (and gap cycle).
  task automatic check_status(input string tag, input logic [2:0] es,
                              input logic eb, input logic eqv);
    checks++;
    if (if_a.slot !== es || if_a.busy !== eb || if_a.q_valid !== eqv) begin
      failures++;
      $display("FAIL %s got slot=%0d busy=%b qv=%b exp slot=%0d busy=%b qv=%b",
               tag, if_a.slot, if_a.busy, if_a.q_valid, es, eb, eqv);
    end
  endtask

  // d[0] is transmitted first; flip inverts the parity bit (parity builds).
  task automatic send_frame(input logic [7:0] d, input bit gaps, input bit flip);
    logic pbit;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        exp_a_q.push_back({PAR & flip, d});
        exp_b_q.push_back({PAR & flip, rev8(d)});
      end
      send_bit(d[k], k == 0);
      check_status("frame_bit", 3'((k + 1) % 8), (k < 7) || PAR, (k == 7) && !PAR);
      if (gaps && k < 7) begin
        din = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        din_valid = 1'b0;
        tick();
        start = 1'b0;
        check_status("gap_hold", 3'(k + 1), 1'b1, 1'b0);
      end
    end
    if (PAR) begin
      pbit = (^d) ^ flip;
      send_bit(pbit, 1'b0);
      check_status("parity_bit", 3'd0, 1'b0, 1'b1);
    end
  endtask

  // One idle cycle after a frame: strobe gone, q holding.
  task automatic check_hold(input logic [7:0] d);
    tick();
    checks++;
    if (if_a.q_valid !== 1'b0 || if_a.parity_err !== 1'b0 || if_a.q !== d || if_b.q !== rev8(d)) begin
      failures++;
      $display("FAIL hold got qv=%b perr=%b qa=%h qb=%h exp qv=0 perr=0 qa=%h qb=%h",
               if_a.q_valid, if_a.parity_err, if_a.q, if_b.q, d, rev8(d));
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending a=%0d b=%0d exp 0", tag, exp_a_q.size(), exp_b_q.size());
      exp_a_q.delete();
      exp_b_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (if_a.q !== 8'h00 || if_a.q_valid !== 1'b0 || if_a.busy !== 1'b0 ||
        if_a.slot !== 3'd0 || if_a.parity_err !== 1'b0 || if_a.state_dbg !== ST_IDLE ||
        if_b.q !== 8'h00) begin
      failures++;
      $display("FAIL reset got q=%h qv=%b busy=%b slot=%0d perr=%b st=%0d qb=%h exp all zero",
               if_a.q, if_a.q_valid, if_a.busy, if_a.slot, if_a.parity_err, if_a.state_dbg, if_b.q);
    end
    // din_valid without start in IDLE is ignored.
    send_bit(1'b1, 1'b0);
    check_status("idle_no_start", 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    send_frame(8'hC5, 1'b0, 1'b0);
    check_hold(8'hC5);
    check_drained("basic");
  endtask

  task automatic test_gaps();
    send_frame(8'hC5, 1'b1, 1'b0);
    check_hold(8'hC5);
    check_drained("gaps");
  endtask

  task automatic test_abort();
    for (int k = 0; k < 4; k++) send_bit(1'b1, k == 0);
    check_status("abort_pre", 3'd4, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0);
    check_hold(8'h0F);
    check_drained("abort");
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) send_bit(1'b1, k == 0);
    check_status("pre_rst", 3'd5, 1'b1, 1'b0);
    rst = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (if_a.busy !== 1'b0 || if_a.slot !== 3'd0 || if_a.q !== 8'h00 || if_a.q_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got busy=%b slot=%0d q=%h qv=%b exp busy=0 slot=0 q=00 qv=0",
               if_a.busy, if_a.slot, if_a.q, if_a.q_valid);
    end
    send_frame(8'h5A, 1'b0, 1'b0);
    check_hold(8'h5A);
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b0, 1'b0);
    end
    check_hold(d);
    check_drained("back_to_back");
  endtask

`ifdef SERIAL_DEMUX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h5A, 1'b0, 1'b0);
    check_hold(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_hold(8'h5A);
    check_drained("parity");
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_DEMUX_PARITY_EN
    test_parity();
`endif
    tick();
    check_drained("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_demux_1_8.md
# serial_demux_1_8

Serial-to-parallel receiver for the 8:1 mux serial link. It is the far end of a link where an 8:1 mux, driven by a 3-bit select counter, sends slots d0..d7 one bit per valid cycle. The block steers each incoming bit into slot 0..7 with an internal 3-bit slot counter (a sequenced 1:8 demux). It presents the assembled byte with a one-cycle valid strobe.

## Interface
Parameters:
- LSB_FIRST, default 1: 1 = first bit of a frame goes to slot 0 (q[0]) and last to slot 7; 0 = first bit goes to q[7].

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- din  in  1  serial data bit
- din_valid  in  1  din is meaningful this cycle
- start  in  1  frame sync; qualified by din_valid, marks the first bit of a frame
- q  out  8  assembled byte; holds the last completed frame
- q_valid  out  1  one-cycle strobe, q updated this cycle
- busy  out  1  high while a frame is being received
- slot  out  3  index of next slot to be written (mirrors transmitter sel)
- parity_err  out  1  one-cycle strobe with q_valid when parity fails (see Configuration)

## Operation
- Reset values: q=8'h00, q_valid=0, busy=0, slot=3'd0, parity_err=0, state=IDLE.
- States: IDLE, RECV, PAR (PAR exists only with PARITY_EN).
- IDLE: din_valid && start -> write din to slot 0, slot<=1, go RECV. din_valid without start is ignored.
- RECV: each din_valid cycle writes din to shift slot `slot`, slot<=slot+1. Cycles without din_valid hold all state.
- After slot 7 is written:
  - Without PARITY_EN: copy the 8-bit buffer to q, pulse q_valid, go IDLE, slot<=0.
  - With PARITY_EN: go PAR.
- PAR: the next din_valid bit is the parity bit. Copy the buffer to q, pulse q_valid, set parity_err = ^{buffer,din}. Go IDLE.
- start && din_valid in RECV or PAR aborts the current frame with no q_valid. That bit becomes slot 0 of a new frame and the block stays in RECV.
- The slot counter wraps 7->0 only via frame completion. It never free-runs.
- Bit mapping: LSB_FIRST=1 puts slot k into q[k]. LSB_FIRST=0 puts slot k into q[7-k].
- busy=1 in RECV and PAR, 0 in IDLE.
- q is never cleared except by rst. It changes only on a q_valid cycle.

## Timing
- q/q_valid are registered. They assert on the clock edge after the last data bit (or parity bit) is sampled: latency 1 cycle from the last bit's sampling edge.
- Minimum frame is 8 consecutive din_valid cycles (9 with parity). Back-to-back frames need no idle gap: start may be asserted on the cycle q_valid is high.
- rst mid-frame discards the partial buffer. Outputs return to reset values on the next edge.
- rst has priority over start/din_valid in the same cycle.

## Configuration
- Macro SERIAL_DEMUX_PARITY_EN.
- Defined: PAR state present, 9-bit frames, even parity checked. parity_err pulses with q_valid on mismatch; q is still delivered.
- Undefined: 8-bit frames, no PAR state, parity_err tied 0.

## Structure
- Shared package/include holds:
  - state encoding constants (IDLE, RECV, PAR);
  - FRAME_BITS=8 and SLOT_W=3 constants, shared with the transmitter-side mux counter.
- One sub-module: demux_1_8, a combinational 1:8 decoder. It turns slot plus a write strobe into 8 per-slot write enables for the buffer register.

## Test plan
- Reset, then frame start on bit 1, bits 1,0,1,0,0,0,1,1 (LSB_FIRST=1) -> q=8'hC5, q_valid high exactly one cycle, 1 cycle after the 8th bit.
- Same bit stream with LSB_FIRST=0 -> q=8'hA3.
- Frame with din_valid gaps (valid every other cycle) -> same q=8'hC5. slot holds during gaps. busy stays high until completion.
- start re-asserted at slot 4, then 8 bits for 8'h0F -> no q_valid for the aborted frame; q=8'h0F once.
- rst asserted at slot 5 -> busy=0, slot=0, q unchanged at reset value 8'h00. A following full frame for 8'h5A is received correctly.
- With SERIAL_DEMUX_PARITY_EN:
  - data 8'h5A with parity 0 -> q=8'h5A, parity_err=0.
  - same data with parity 1 -> q=8'h5A, parity_err=1 for one cycle.
